dice_roll_capture: RTL and testbench

//  Reader side of the free-running modulo dice counter: turns a player button press/release into one

---
 rtl/dice_pkg.sv | 24 ++
 rtl/dice_roll_capture_btn_debounce.sv | 60 ++++++
 rtl/dice_roll_capture.sv | 90 +++++++++
 tb/tb_dice_roll_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice capture block: FSM state encoding
// and the counter-value to die-face mapping.
package dice_pkg;

    localparam int DEF_FACES    = 6;
    localparam int DEF_BUS_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_VALID   = 2'd2
    } state_e;

    // Out-of-range counter values collapse to face 1 so the result is never 0 or >faces.
    function automatic int unsigned face_of(input int unsigned cnt, input int unsigned faces);
        int unsigned face;
        face = 1;
        if (cnt < faces) begin
            face = cnt + 1;
        end
        return face;
    endfunction

endpackage

// File: rtl/dice_roll_capture_btn_debounce.sv
// Button conditioning: two-flop synchroniser, stable-level debounce counter
// and one-cycle rise/fall pulses derived from the registered debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db,
    output logic rise,
    output logic fall
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle where the synchronised level agrees with the accepted level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_d <= 1'b0;
        end else begin
            r_db_d <= r_db;
        end
    end

    assign btn_db = r_db;
    assign rise   = r_db & ~r_db_d;
    assign fall   = ~r_db & r_db_d;

endmodule

// File: rtl/dice_roll_capture.sv
// Dice reader: debounced button press shows a live face, release captures it,
// and the captured face is offered with valid/ack to the score logic.
import dice_pkg::*;

module dice_roll_capture #(
    parameter int BUS_SIZE        = DEF_BUS_SIZE,
    parameter int FACES           = DEF_FACES,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn,
    input  logic [BUS_SIZE-1:0] cnt_q,
    output logic                rolling,
    output logic [BUS_SIZE-1:0] result,
    output logic                result_valid,
    input  logic                result_ack,
    output state_e              o_dbg_state
);

    // Handshake: result is stable while result_valid=1; a cycle with result_valid=1 and
    // result_ack=1 completes the transfer and result_valid drops on the next cycle.

    logic                w_btn_db;
    logic                w_rise;
    logic                w_fall;
    logic [BUS_SIZE-1:0] w_face;

    state_e              r_state;
    logic                r_rolling;
    logic [BUS_SIZE-1:0] r_result;
    logic                r_result_valid;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .btn_db (w_btn_db),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_face = BUS_SIZE'(face_of(32'(cnt_q), FACES));

    // Presses seen in VALID are edge events only and are dropped, including one coinciding with ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_rolling      <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_ROLLING;
                        r_rolling <= 1'b1;
                    end
                end
                ST_ROLLING: begin
                    r_result <= w_face;
                    if (w_fall) begin
                        r_state        <= ST_VALID;
                        r_rolling      <= 1'b0;
                        r_result_valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (result_ack) begin
                        r_state        <= ST_IDLE;
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_rolling      <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rolling      = r_rolling;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_dice_roll_capture.sv
// Directed bench for dice_roll_capture with DEBOUNCE_CYCLES=4, FACES=6.
module tb_dice_roll_capture;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] cnt_q;
    logic       rolling;
    logic [3:0] result;
    logic       result_valid;
    logic       result_ack;
    logic [1:0] dbg_state;

    int total;
    int bad;

    dice_roll_capture #(
        .BUS_SIZE(4),
        .FACES(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn          (btn),
        .cnt_q        (cnt_q),
        .rolling      (rolling),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Press, hold, release with cnt_q=cnt_val; release-to-valid latency is 2+4+1 cycles.
    task automatic roll(input string tag, input logic [3:0] cnt_val, input logic [3:0] face_exp,
                        input int hold);
        btn = 1'b1;
        step(7);
        chk({tag, "_rolling"}, 32'(rolling), 1);
        chk({tag, "_state_roll"}, 32'(dbg_state), 1);
        step(hold);
        cnt_q = cnt_val;
        btn   = 1'b0;
        step(6);
        chk({tag, "_valid_early"}, 32'(result_valid), 0);
        step(1);
        chk({tag, "_valid"}, 32'(result_valid), 1);
        chk({tag, "_result"}, 32'(result), 32'(face_exp));
        chk({tag, "_rolling_off"}, 32'(rolling), 0);
    endtask

    task automatic ack_it(input string tag);
        result_ack = 1'b1;
        step(1);
        result_ack = 1'b0;
        chk({tag, "_ack_valid"}, 32'(result_valid), 0);
        chk({tag, "_ack_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        btn        = 1'b0;
        cnt_q      = 4'd0;
        result_ack = 1'b0;
        #1;
        chk("rst_rolling", 32'(rolling), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_state", 32'(dbg_state), 0);
        step(2);
        rst = 1'b0;
        step(2);
        chk("post_rst_state", 32'(dbg_state), 0);

        // Clean roll: 20-cycle press, capture cnt_q=3 -> face 4, hold valid 10 cycles.
        cnt_q = 4'd3;
        roll("clean", 4'd3, 4'd4, 13);
        for (int i = 0; i < 10; i++) begin
            cnt_q = 4'(i % 6);
            step(1);
            chk("clean_hold_valid", 32'(result_valid), 1);
            chk("clean_hold_result", 32'(result), 4);
        end
        ack_it("clean");
        chk("clean_keep_result", 32'(result), 4);
        step(3);
        chk("clean_keep_result2", 32'(result), 4);
        chk("clean_idle_valid", 32'(result_valid), 0);

        // Ack outside VALID has no effect.
        result_ack = 1'b1;
        step(3);
        result_ack = 1'b0;
        chk("stray_ack_state", 32'(dbg_state), 0);
        chk("stray_ack_result", 32'(result), 4);

        // Bounce: high pulses 1..3 cycles wide never survive the debounce.
        for (int i = 0; i < 8; i++) begin
            btn = 1'b1;
            step((i % 3) + 1);
            chk("bounce_rolling_hi", 32'(rolling), 0);
            btn = 1'b0;
            step(((i + 1) % 2) + 1);
            chk("bounce_rolling_lo", 32'(rolling), 0);
            chk("bounce_valid", 32'(result_valid), 0);
        end
        step(8);
        chk("bounce_state", 32'(dbg_state), 0);
        chk("bounce_valid_end", 32'(result_valid), 0);

        // Wrap / range.
        roll("wrap5", 4'd5, 4'd6, 4);
        ack_it("wrap5");
        roll("wrap0", 4'd0, 4'd1, 4);
        ack_it("wrap0");
        roll("range9", 4'd9, 4'd1, 4);
        ack_it("range9");

        // Reset mid-VALID discards the captured face immediately.
        roll("pre_rst", 4'd4, 4'd5, 3);
        rst = 1'b1;
        #1;
        chk("midrst_rolling", 32'(rolling), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_valid", 32'(result_valid), 0);
        chk("midrst_state", 32'(dbg_state), 0);
        step(1);
        rst = 1'b0;
        step(2);
        chk("midrst_result_after", 32'(result), 0);

        // Press during VALID is ignored.
        roll("pv", 4'd1, 4'd2, 4);
        cnt_q = 4'd5;
        btn   = 1'b1;
        step(10);
        chk("pv_state", 32'(dbg_state), 2);
        chk("pv_result", 32'(result), 2);
        chk("pv_rolling", 32'(rolling), 0);
        btn = 1'b0;
        step(8);
        chk("pv_state_rel", 32'(dbg_state), 2);

        // Ack in the same cycle as the debounced rise: ack wins, rise is lost.
        btn = 1'b1;
        step(6);
        result_ack = 1'b1;
        step(1);
        result_ack = 1'b0;
        chk("ackrise_state", 32'(dbg_state), 0);
        chk("ackrise_valid", 32'(result_valid), 0);
        chk("ackrise_rolling", 32'(rolling), 0);
        step(10);
        chk("ackrise_held_rolling", 32'(rolling), 0);
        chk("ackrise_held_state", 32'(dbg_state), 0);
        btn = 1'b0;
        step(8);
        roll("repress", 4'd2, 4'd3, 5);
        ack_it("repress");

        // Live display follows cnt_q one cycle later while rolling.
        btn = 1'b1;
        step(7);
        chk("live_rolling", 32'(rolling), 1);
        for (int i = 0; i < 6; i++) begin
            cnt_q = 4'(i);
            step(1);
            chk("live_result", 32'(result), 32'(i + 1));
            chk("live_rolling_hold", 32'(rolling), 1);
        end
        cnt_q = 4'd2;
        btn   = 1'b0;
        step(7);
        chk("live_final_valid", 32'(result_valid), 1);
        chk("live_final_result", 32'(result), 3);
        ack_it("live");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
